lvds_rx_deser: RTL and testbench

//  Serial-to-parallel front end for the LVDS receive path. Samples LVDS_DATA on LVDS_CLK while the frame gate LVDS_VS is high.

---
 rtl/lvds_rx_deser.sv | 155 +++++++++++++++
 tb/tb_lvds_rx_deser.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_rx_deser.sv
// LVDS serial-to-parallel receiver: MSB-first words, frame index, frame status.
// Optional per-word even-parity bit with `define LVDS_RX_PARITY_EN.
module lvds_rx_deser #(
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 512,
  parameter int IDX_W     = 9
) (
  input  logic              LVDS_CLK,
  input  logic              RSTn,
  input  logic              LVDS_VS,
  input  logic              LVDS_DATA,
  input  logic              ERR_CLEAR,
  output logic [DATA_W-1:0] WORD_DATA,
  output logic              WORD_VALID,
  output logic              WORD_SOF,
  output logic [IDX_W-1:0]  WORD_IDX,
  output logic              WORD_PERR,
  output logic              FRAME_DONE,
  output logic [IDX_W:0]    FRAME_WORDS,
  output logic              ERR_PARTIAL,
  output logic              ERR_OVF
);

`ifdef LVDS_RX_PARITY_EN
  localparam int WORD_BITS = DATA_W + 1;
`else
  localparam int WORD_BITS = DATA_W;
`endif
  localparam int CNT_W = $clog2(WORD_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);
  localparam logic [IDX_W:0] MAX_CNT = (IDX_W + 1)'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_WAIT_LOW,
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WORD_BITS-1:0] r_shift;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [IDX_W:0]       r_word_cnt;
  logic [DATA_W-1:0]    r_data;
  logic                 r_valid;
  logic                 r_sof;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_perr;
  logic                 r_done;
  logic [IDX_W:0]       r_frame_words;
  logic                 r_err_part;
  logic                 r_err_ovf;

  logic [WORD_BITS-1:0] w_shift_in;
  logic                 w_start;
  logic                 w_shift;
  logic                 w_word_end;
  logic                 w_deliver;
  logic                 w_drop;
  logic                 w_close;
  logic                 w_part;
  logic [DATA_W-1:0]    w_word;
  logic                 w_perr;

  assign w_shift_in = {r_shift[WORD_BITS-2:0], LVDS_DATA};
  assign w_start    = (r_state == S_IDLE) && LVDS_VS;
  assign w_shift    = (r_state == S_SHIFT) && LVDS_VS;
  assign w_close    = (r_state == S_SHIFT) && !LVDS_VS;
  assign w_word_end = w_shift && (r_bit_cnt == LAST_BIT);
  assign w_deliver  = w_word_end && (r_word_cnt < MAX_CNT);
  assign w_drop     = w_word_end && !(r_word_cnt < MAX_CNT);
  assign w_part     = w_close && (r_bit_cnt != '0);

`ifdef LVDS_RX_PARITY_EN
  assign w_word = w_shift_in[DATA_W:1];
  assign w_perr = ^w_shift_in;
`else
  assign w_word = w_shift_in;
  assign w_perr = 1'b0;
`endif

  always_ff @(posedge LVDS_CLK or negedge RSTn) begin
    if (!RSTn) r_state <= S_WAIT_LOW;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_WAIT_LOW: if (!LVDS_VS) w_next = S_IDLE;
      S_IDLE:     if (LVDS_VS)  w_next = S_SHIFT;
      S_SHIFT:    if (!LVDS_VS) w_next = S_IDLE;
      default:    w_next = S_WAIT_LOW;
    endcase
  end

  always_ff @(posedge LVDS_CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_word_cnt    <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_sof         <= 1'b0;
      r_idx         <= '0;
      r_perr        <= 1'b0;
      r_done        <= 1'b0;
      r_frame_words <= '0;
      r_err_part    <= 1'b0;
      r_err_ovf     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_perr  <= 1'b0;
      r_done  <= 1'b0;
      if (w_start) begin
        r_shift    <= w_shift_in;
        r_bit_cnt  <= CNT_W'(1);
        r_word_cnt <= '0;
      end
      if (w_shift) begin
        r_shift   <= w_shift_in;
        r_bit_cnt <= w_word_end ? '0 : r_bit_cnt + CNT_W'(1);
      end
      if (w_deliver) begin
        r_data     <= w_word;
        r_idx      <= r_word_cnt[IDX_W-1:0];
        r_sof      <= (r_word_cnt == '0);
        r_perr     <= w_perr;
        r_valid    <= 1'b1;
        r_word_cnt <= r_word_cnt + (IDX_W + 1)'(1);
      end
      // Closing sample's bit is discarded; partial word is dropped here
      if (w_close) begin
        r_done        <= 1'b1;
        r_frame_words <= r_word_cnt;
        r_bit_cnt     <= '0;
      end
      r_err_part <= w_part | (r_err_part & ~ERR_CLEAR);
      r_err_ovf  <= w_drop | (r_err_ovf & ~ERR_CLEAR);
    end
  end

  assign WORD_DATA   = r_data;
  assign WORD_VALID  = r_valid;
  assign WORD_SOF    = r_sof;
  assign WORD_IDX    = r_idx;
  assign WORD_PERR   = r_perr;
  assign FRAME_DONE  = r_done;
  assign FRAME_WORDS = r_frame_words;
  assign ERR_PARTIAL = r_err_part;
  assign ERR_OVF     = r_err_ovf;

endmodule

// File: tb/tb_lvds_rx_deser.sv
// Bench for lvds_rx_deser: frame table plus hand sequences, word scoreboard.
// Define LVDS_RX_PARITY_EN to exercise the parity build.
module tb_lvds_rx_deser;

`ifdef LVDS_RX_PARITY_EN
  localparam int WB = 33;
`else
  localparam int WB = 32;
`endif

  logic        LVDS_CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        LVDS_VS = 1'b0;
  logic        LVDS_DATA = 1'b0;
  logic        ERR_CLEAR = 1'b0;
  logic [31:0] WORD_DATA;
  logic        WORD_VALID;
  logic        WORD_SOF;
  logic [8:0]  WORD_IDX;
  logic        WORD_PERR;
  logic        FRAME_DONE;
  logic [9:0]  FRAME_WORDS;
  logic        ERR_PARTIAL;
  logic        ERR_OVF;

  lvds_rx_deser dut (
    .LVDS_CLK    (LVDS_CLK),
    .RSTn        (RSTn),
    .LVDS_VS     (LVDS_VS),
    .LVDS_DATA   (LVDS_DATA),
    .ERR_CLEAR   (ERR_CLEAR),
    .WORD_DATA   (WORD_DATA),
    .WORD_VALID  (WORD_VALID),
    .WORD_SOF    (WORD_SOF),
    .WORD_IDX    (WORD_IDX),
    .WORD_PERR   (WORD_PERR),
    .FRAME_DONE  (FRAME_DONE),
    .FRAME_WORDS (FRAME_WORDS),
    .ERR_PARTIAL (ERR_PARTIAL),
    .ERR_OVF     (ERR_OVF)
  );

  always #5 LVDS_CLK = ~LVDS_CLK;

  typedef struct packed {
    logic [31:0] d;
    logic [8:0]  idx;
    logic        sof;
    logic        perr;
  } exp_t;

  typedef struct {
    int          nbits;
    logic [31:0] w0;
    logic [31:0] w1;
    int          ew;
    bit          ep;
    bit          eo;
    bit          clr;
  } vec_t;

  exp_t q[$];
  vec_t tv[6];
  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int done_exp = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] w0,
                                          input logic [31:0] w1,
                                          input int k);
    if (k == 0) return w0;
    if (k == 1) return w1;
    return w1 ^ (32'(k) * 32'h9E3779B9);
  endfunction

  exp_t e;
  always @(negedge LVDS_CLK) begin
    if (FRAME_DONE === 1'b1) done_seen++;
    if (WORD_VALID === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_word", 64'(WORD_IDX), 64'hFFFF);
      end else begin
        e = q.pop_front();
        chk("word_data", 64'(WORD_DATA), 64'(e.d));
        chk("word_idx", 64'(WORD_IDX), 64'(e.idx));
        chk("word_sof", 64'(WORD_SOF), 64'(e.sof));
        chk("word_perr", 64'(WORD_PERR), 64'(e.perr));
      end
    end
  end

  // Caller sits 1 time unit after a rising edge; so does the task on exit.
  task automatic drive_bits(input int nbits, input logic [31:0] w0,
                            input logic [31:0] w1, input bit badp);
    int k;
    int b;
    logic [31:0] w;
    exp_t x;
    for (int i = 0; i < nbits; i++) begin
      k = i / WB;
      b = i % WB;
      w = word_of(w0, w1, k);
      LVDS_VS = 1'b1;
      if (b < 32) LVDS_DATA = w[31-b];
      else LVDS_DATA = (^w) ^ (badp && k == 0);
      if (b == WB - 1 && k < 512) begin
        x.d = w;
        x.idx = 9'(k);
        x.sof = (k == 0);
        x.perr = (WB == 33) && badp && (k == 0);
        q.push_back(x);
      end
      @(posedge LVDS_CLK);
      #1;
    end
  endtask

  task automatic close_frame(input int ew, input bit ep, input bit eo,
                             input bit clr);
    LVDS_VS = 1'b0;
    LVDS_DATA = 1'b1;
    ERR_CLEAR = clr;
    done_exp++;
    @(posedge LVDS_CLK);
    #1;
    ERR_CLEAR = 1'b0;
    chk("frame_done", 64'(FRAME_DONE), 64'd1);
    chk("frame_words", 64'(FRAME_WORDS), 64'(ew));
    chk("err_partial", 64'(ERR_PARTIAL), 64'(ep));
    chk("err_ovf", 64'(ERR_OVF), 64'(eo));
  endtask

  task automatic idle(input int n);
    LVDS_VS = 1'b0;
    repeat (n) begin
      @(posedge LVDS_CLK);
      #1;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {WORD_DATA, WORD_IDX, WORD_VALID, WORD_SOF, WORD_PERR,
             FRAME_DONE, FRAME_WORDS, ERR_PARTIAL, ERR_OVF}, 64'd0);
  endtask

  initial begin
    tv[0] = '{2 * WB, 32'hDEADBEEF, 32'h12345678, 2, 0, 0, 0};
    tv[1] = '{WB + 8, 32'hC0FFEE00, 32'h0, 1, 1, 0, 1};
    tv[2] = '{513 * WB, 32'h5A5AA5A5, 32'h0F0F1234, 512, 0, 1, 1};
    tv[3] = '{3 * WB, 32'h80000001, 32'h7FFFFFFE, 3, 0, 0, 0};
    tv[4] = '{5, 32'hFFFFFFFF, 32'h0, 0, 1, 0, 1};
    tv[5] = '{512 * WB, 32'h01234567, 32'h89ABCDEF, 512, 0, 0, 0};

    #2;
    chk_zero("reset_outputs");
    @(posedge LVDS_CLK);
    #1;
    RSTn = 1'b1;
    idle(3);

    for (int t = 0; t < 6; t++) begin
      drive_bits(tv[t].nbits, tv[t].w0, tv[t].w1, 1'b0);
      close_frame(tv[t].ew, tv[t].ep, tv[t].eo, 1'b0);
      idle(2);
      if (tv[t].clr) begin
        ERR_CLEAR = 1'b1;
        @(posedge LVDS_CLK);
        #1;
        ERR_CLEAR = 1'b0;
        chk("clear_partial", 64'(ERR_PARTIAL), 64'd0);
        chk("clear_ovf", 64'(ERR_OVF), 64'd0);
      end
    end

    // Reset in the middle of word 3; the rest of that frame is ignored
    drive_bits(3 * WB + 10, 32'hCAFEF00D, 32'hBEEFCAFE, 1'b0);
    RSTn = 1'b0;
    #2;
    chk_zero("midframe_reset");
    @(posedge LVDS_CLK);
    #1;
    RSTn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      LVDS_VS = 1'b1;
      LVDS_DATA = 1'($urandom);
      @(posedge LVDS_CLK);
      #1;
    end
    LVDS_VS = 1'b0;
    @(posedge LVDS_CLK);
    #1;
    chk("no_done_after_reset", 64'(FRAME_DONE), 64'd0);
    idle(1);
    drive_bits(2 * WB, 32'h13579BDF, 32'h2468ACE0, 1'b0);
    close_frame(2, 0, 0, 0);

    // One-cycle gaps between frames, then clear colliding with a new error
    idle(2);
    drive_bits(WB, 32'hA5A5A5A5, 32'h0, 1'b0);
    close_frame(1, 0, 0, 0);
    drive_bits(WB, 32'h3C3C3C3C, 32'h0, 1'b0);
    close_frame(1, 0, 0, 0);
    drive_bits(WB + 3, 32'h11112222, 32'h0, 1'b0);
    close_frame(1, 1, 0, 1);
    idle(2);

`ifdef LVDS_RX_PARITY_EN
    drive_bits(WB, 32'h00000001, 32'h0, 1'b1);
    close_frame(1, 1, 0, 0);
    drive_bits(WB, 32'h00000001, 32'h0, 1'b0);
    close_frame(1, 1, 0, 0);
    idle(2);
`endif

    idle(3);
    chk("queue_empty", 64'(q.size()), 64'd0);
    chk("done_count", 64'(done_seen), 64'(done_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
